// File: rtl/timer_match_n.sv
// General-purpose timer: prescaler feeding a timer counter with NUM_MATCH compare
// channels, each with sticky interrupt, counter reset/stop and match-pin control.
module timer_match_n #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_MATCH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     tcr,
    input  logic [WIDTH-1:0]               pr,
    input  logic [NUM_MATCH*WIDTH-1:0]     mr,
    input  logic [3*NUM_MATCH-1:0]         mcr,
    input  logic [2*NUM_MATCH-1:0]         emc,
    input  logic [NUM_MATCH-1:0]           int_clr,
    output logic [WIDTH-1:0]               pc,
    output logic [WIDTH-1:0]               tc,
    output logic [NUM_MATCH-1:0]           int_flag,
    output logic                           irq,
    output logic [NUM_MATCH-1:0]           match_out,
    output logic                           stopped
);

    localparam int unsigned CH_W = NUM_MATCH;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic [CH_W-1:0]  int_flag_q, int_flag_d;
    logic [CH_W-1:0]  match_out_q, match_out_d;
    logic             stopped_q, stopped_d;
    logic             irq_q, irq_d;

    logic             run_c;
    logic             tick_c;
    logic [CH_W-1:0]  match_c;
    logic             rst_hit_c;
    logic             stop_hit_c;

    // Tick generation and per-channel compare against the pre-update counter.
    always_comb begin
        run_c      = tcr[0] & ~tcr[1] & ~stopped_q;
        tick_c     = run_c & (pc_q == pr);
        match_c    = '0;
        rst_hit_c  = 1'b0;
        stop_hit_c = 1'b0;
        for (int unsigned i = 0; i < NUM_MATCH; i++) begin
            match_c[i] = tick_c & (tc_q == mr[i*WIDTH +: WIDTH]);
            rst_hit_c  = rst_hit_c  | (match_c[i] & mcr[3*i+1]);
            stop_hit_c = stop_hit_c | (match_c[i] & mcr[3*i+2]);
        end
    end

    // Next-state for counters, stop latch, flags and match pins.
    always_comb begin
        pc_d        = pc_q;
        tc_d        = tc_q;
        stopped_d   = stopped_q;
        int_flag_d  = int_flag_q;
        match_out_d = match_out_q;

        if (tcr[1]) begin
            pc_d = '0;
        end else if (run_c) begin
            pc_d = tick_c ? '0 : pc_q + WIDTH'(1);
        end

        if (tcr[1]) begin
            tc_d = '0;
        end else if (tick_c && rst_hit_c) begin
            tc_d = '0;
        end else if (tick_c) begin
            tc_d = tc_q + WIDTH'(1);
        end

        // Disabling or resetting the counter releases a stop-on-match halt.
        if (!tcr[0] || tcr[1]) begin
            stopped_d = 1'b0;
        end else if (stop_hit_c) begin
            stopped_d = 1'b1;
        end

        for (int unsigned i = 0; i < NUM_MATCH; i++) begin
            if (match_c[i] && mcr[3*i]) begin
                int_flag_d[i] = 1'b1;
            end else if (int_clr[i]) begin
                int_flag_d[i] = 1'b0;
            end

            if (match_c[i]) begin
                case (emc[2*i +: 2])
                    2'b01:   match_out_d[i] = 1'b0;
                    2'b10:   match_out_d[i] = 1'b1;
                    2'b11:   match_out_d[i] = ~match_out_q[i];
                    default: match_out_d[i] = match_out_q[i];
                endcase
            end
        end

        irq_d = |int_flag_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= '0;
            tc_q        <= '0;
            stopped_q   <= 1'b0;
            int_flag_q  <= '0;
            match_out_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            tc_q        <= tc_d;
            stopped_q   <= stopped_d;
            int_flag_q  <= int_flag_d;
            match_out_q <= match_out_d;
            irq_q       <= irq_d;
        end
    end

    assign pc        = pc_q;
    assign tc        = tc_q;
    assign int_flag  = int_flag_q;
    assign irq       = irq_q;
    assign match_out = match_out_q;
    assign stopped   = stopped_q;

endmodule

// File: tb/tb_timer_match_n.sv
// Scoreboard bench for timer_match_n: the driver queues hand-computed expected
// output snapshots and a monitor process pops and compares them.
module tb_timer_match_n;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       tcr;
    logic [W-1:0]     pr;
    logic [N*W-1:0]   mr;
    logic [3*N-1:0]   mcr;
    logic [2*N-1:0]   emc;
    logic [N-1:0]     int_clr;
    logic [W-1:0]     pc;
    logic [W-1:0]     tc;
    logic [N-1:0]     int_flag;
    logic             irq;
    logic [N-1:0]     match_out;
    logic             stopped;

    timer_match_n #(.WIDTH(W), .NUM_MATCH(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .tcr       (tcr),
        .pr        (pr),
        .mr        (mr),
        .mcr       (mcr),
        .emc       (emc),
        .int_clr   (int_clr),
        .pc        (pc),
        .tc        (tc),
        .int_flag  (int_flag),
        .irq       (irq),
        .match_out (match_out),
        .stopped   (stopped)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] pc;
        logic [W-1:0] tc;
        logic [N-1:0] flag;
        logic [N-1:0] mo;
        logic         st;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_st(input string name, input logic [W-1:0] pc_e,
                             input logic [W-1:0] tc_e, input logic [N-1:0] flag_e,
                             input logic [N-1:0] mo_e, input logic st_e);
        exp_t e;
        e.name = name;
        e.pc   = pc_e;
        e.tc   = tc_e;
        e.flag = flag_e;
        e.mo   = mo_e;
        e.st   = st_e;
        exp_q.push_back(e);
        -> sample_ev;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare the full output snapshot against each queued expectation.
    initial begin
        exp_t e;
        logic [2*W+2*N+1:0] act;
        logic [2*W+2*N+1:0] req;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pc, tc, int_flag, irq, match_out, stopped};
                req = {e.pc, e.tc, e.flag, |e.flag, e.mo, e.st};
                n_cmp++;
                if (act !== req) begin
                    n_bad++;
                    $display("FAIL %s: got pc=%0d tc=%0d flag=%b irq=%b mo=%b stopped=%b, want pc=%0d tc=%0d flag=%b irq=%b mo=%b stopped=%b",
                             e.name, pc, tc, int_flag, irq, match_out, stopped,
                             e.pc, e.tc, e.flag, |e.flag, e.mo, e.st);
                end
            end
        end
    end

    initial begin
        reset   = 1'b0;
        tcr     = 2'b00;
        pr      = '0;
        mr      = '0;
        mcr     = '0;
        emc     = '0;
        int_clr = '0;
        #1;
        expect_st("reset_state", 0, 0, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk) reset = 1'b1;

        // Free-run with prescale 3, ch0 interrupt + reset at tc==3.
        @(negedge clk);
        pr = 8'd3; mr[0*W +: W] = 8'd3; mcr = 12'b000_000_000_011; tcr = 2'b01;
        step(4);
        expect_st("presc_first_tick", 0, 1, 4'b0000, 4'b0000, 1'b0);
        step(11);
        expect_st("presc_edge15", 3, 3, 4'b0000, 4'b0000, 1'b0);
        step(1);
        expect_st("match0_int_reset", 0, 0, 4'b0001, 4'b0000, 1'b0);

        @(negedge clk);
        tcr = 2'b10; int_clr = 4'b0001;
        step(1);
        expect_st("sync_reset_clr", 0, 0, 4'b0000, 4'b0000, 1'b0);

        // Stop on match: ch1 at tc==5, prescale 0.
        @(negedge clk);
        int_clr = '0; pr = 8'd0; mr[1*W +: W] = 8'd5; mcr = 12'b000_000_100_000; tcr = 2'b01;
        step(5);
        expect_st("stop_before", 0, 5, 4'b0000, 4'b0000, 1'b0);
        step(1);
        expect_st("stop_hit", 0, 6, 4'b0000, 4'b0000, 1'b1);
        step(3);
        expect_st("stop_hold", 0, 6, 4'b0000, 4'b0000, 1'b1);
        @(negedge clk) tcr = 2'b00;
        step(1);
        expect_st("stop_release", 0, 6, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk) tcr = 2'b01;
        step(2);
        expect_st("stop_resume", 0, 8, 4'b0000, 4'b0000, 1'b0);

        // External toggle on ch2 (reset at tc==2), then set action.
        @(negedge clk) tcr = 2'b10;
        step(1);
        @(negedge clk);
        mr[2*W +: W] = 8'd2; mcr = 12'b000_010_000_000; emc = 8'b00_11_00_00; tcr = 2'b01;
        step(3);
        expect_st("toggle_1", 0, 0, 4'b0000, 4'b0100, 1'b0);
        step(3);
        expect_st("toggle_0", 0, 0, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk) emc = 8'b00_10_00_00;
        step(3);
        expect_st("set_1", 0, 0, 4'b0000, 4'b0100, 1'b0);
        step(3);
        expect_st("set_hold", 0, 0, 4'b0000, 4'b0100, 1'b0);

        // Flag set/clear race on ch0.
        @(negedge clk);
        tcr = 2'b10; mr[0*W +: W] = 8'd2; mcr = 12'b000_000_000_011; emc = '0;
        step(1);
        @(negedge clk) tcr = 2'b01;
        step(2);
        @(negedge clk) int_clr = 4'b0001;
        step(1);
        expect_st("race_set_wins", 0, 0, 4'b0001, 4'b0100, 1'b0);
        @(negedge clk) int_clr = 4'b0000;
        step(1);
        @(negedge clk) int_clr = 4'b0001;
        step(1);
        expect_st("lone_clear", 0, 2, 4'b0000, 4'b0100, 1'b0);

        // Wrap at 255 with ch3 interrupt at 250, then sync reset held.
        @(negedge clk);
        int_clr = '0; tcr = 2'b10; mr[3*W +: W] = 8'd250; mcr = 12'b001_000_000_000;
        step(1);
        @(negedge clk) tcr = 2'b01;
        step(255);
        expect_st("tc_255", 0, 255, 4'b1000, 4'b0100, 1'b0);
        step(1);
        expect_st("tc_wrap", 0, 0, 4'b1000, 4'b0100, 1'b0);
        step(5);
        @(negedge clk) tcr = 2'b11;
        step(1);
        expect_st("tcr11_clear", 0, 0, 4'b1000, 4'b0100, 1'b0);
        step(3);
        expect_st("tcr11_hold", 0, 0, 4'b1000, 4'b0100, 1'b0);

        // Asynchronous reset between edges.
        @(negedge clk) tcr = 2'b01;
        step(3);
        expect_st("pre_async", 0, 3, 4'b1000, 4'b0100, 1'b0);
        #2 reset = 1'b0;
        #1;
        expect_st("async_reset", 0, 0, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk) reset = 1'b1;
        step(2);
        expect_st("post_async", 0, 2, 4'b0000, 4'b0000, 1'b0);

        #1;
        -> sample_ev;
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_match_n.md
Name: timer_match_n

Overview:
- Parametrised general-purpose timer: prescaler plus timer counter (TC) with NUM_MATCH match channels.
- Each channel has per-channel interrupt/reset/stop control and a per-channel external match output action (nothing/clear/set/toggle).
- Adds sticky interrupt flags with software clear, and a stop-on-match latch.
- Sits on the peripheral side; control registers are driven by a register file or bench.

Parameters:
- WIDTH, 32, width of prescaler, TC and match registers.
- NUM_MATCH, 4, number of match channels (1..8).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- tcr  input  2  bit0 counter enable; bit1 synchronous counter reset (priority over enable).
- pr  input  WIDTH  prescale limit; TC advances once every pr+1 enabled cycles.
- mr  input  NUM_MATCH*WIDTH  match values, channel i at bits [i*WIDTH +: WIDTH].
- mcr  input  3*NUM_MATCH  per channel i, bits [3i +: 3]: bit0 interrupt enable, bit1 reset TC on match, bit2 stop on match.
- emc  input  2*NUM_MATCH  per channel i, bits [2i +: 2]: external match action 00 none, 01 clear, 10 set, 11 toggle.
- int_clr  input  NUM_MATCH  one bit per channel; 1 clears that channel's interrupt flag.
- pc  output  WIDTH  prescale counter.
- tc  output  WIDTH  timer counter.
- int_flag  output  NUM_MATCH  sticky per-channel interrupt flags.
- irq  output  1  OR of int_flag.
- match_out  output  NUM_MATCH  external match pins.
- stopped  output  1  set when a stop-on-match has halted the timer.

Behaviour:
- Reset (reset=0, asynchronous): pc=0, tc=0, int_flag=0, match_out=0, stopped=0; irq=0.
- run = tcr[0] & ~tcr[1] & ~stopped.
- tick = run & (pc == pr); combinational, internal.
- Prescaler, each rising edge:
  - tcr[1]=1: pc<=0.
  - else if run: pc <= tick ? 0 : pc+1.
  - else pc holds.
- Match event, per channel: m[i] = tick & (tc == mr[i]); evaluated on the current (pre-update) tc.
- TC update, each rising edge:
  - tcr[1]=1: tc<=0.
  - else if tick and any m[i] with mcr reset bit: tc<=0.
  - else if tick: tc<=tc+1, wrapping 2^WIDTH-1 -> 0.
  - else tc holds.
- Stop on match:
  - Any m[i] with stop bit set: stopped<=1.
  - TC takes reset-to-0 if that channel's reset bit is also set, otherwise tc<=tc+1 on that final tick.
  - stopped clears when tcr[0]=0 or tcr[1]=1; clearing takes priority over a stop-on-match in the same cycle.
  - While stopped, pc and tc hold.
- Interrupt flags:
  - int_flag[i] <= 1 on m[i] & mcr int bit.
  - Cleared by int_clr[i]=1.
  - Simultaneous set and clear: set wins.
  - Flags are unaffected by tcr.
  - irq is combinational OR, same cycle as flags.
- External match: on m[i], match_out[i] updated per emc[i] on that edge; otherwise holds. Unaffected by tcr[1] and stop.
- Latency: a match is evaluated on the edge where tick and tc==mr[i]; flag, match_out and tc effects are visible after that same edge.
- Multiple channels matching on the same tick:
  - All flags and outputs update independently.
  - Reset dominates increment.
- pr=0: tick every run cycle, pc stays 0.
- mr changed mid-count: compare uses the current value; no latching.
- If mr[i] is never reached, TC wraps normally.
- Asynchronous reset deasserted mid-operation: counting resumes from 0 on the first edge with run=1.

Test Plan:
- Free-run, basic match:
  - Stimulus: NUM_MATCH=4, pr=3, mr0=3, mcr ch0=011 (int+reset), tcr=01.
  - tc sequence 0,1,2,3,0,... with a tick every 4 clk.
  - int_flag[0] set after the 16th enabled edge; irq=1.
  - tc=0 after that same edge.
- Stop on match:
  - Stimulus: pr=0, mr1=5, mcr ch1=100.
  - tc reaches 6 and holds, stopped=1.
  - tcr=00 then 01 clears stopped; counting resumes from 6.
- External toggle:
  - Stimulus: pr=0, mr2=2, mcr ch2=010, emc ch2=11.
  - match_out[2] toggles every 3 clk: 0 -> 1 -> 0.
  - Same setup with emc=10: stays 1 after the first match.
- Flag clear race:
  - Stimulus: int_clr[0]=1 asserted on the same edge as an m[0] event with int enabled.
  - int_flag[0] remains 1; the next lone int_clr[0] pulse clears it; irq=0.
- Counter reset and wrap:
  - Stimulus: WIDTH=8, pr=0, no match enables.
  - tc 255 -> 0 wrap.
  - tcr=11 mid-count forces pc=tc=0 and holds while asserted; match_out and int_flag unchanged.
- Asynchronous reset:
  - Stimulus: reset=0 asserted between clock edges mid-count.
  - All outputs 0 immediately, without waiting for a clock edge.
